// File: rtl/reg_bus_arb.sv
// reg_bus_arb: shares the register bus between MASTERS requesters; define ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module reg_bus_arb #(
    parameter int MASTERS    = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    sclr,
    input  logic [MASTERS-1:0]      m_req,
    input  logic [MASTERS-1:0]      m_we,
    input  logic [16*MASTERS-1:0]   m_addr,
    input  logic [16*MASTERS-1:0]   m_wdata,
    input  logic [2*MASTERS-1:0]    m_be,
    output logic [MASTERS-1:0]      m_gnt,
    output logic [MASTERS-1:0]      m_done,
    output logic [15:0]             m_rdata,
    output logic [15:0]             rdaddr,
    output logic [15:0]             wraddr,
    output logic [1:0]              be,
    output logic                    write,
    output logic [15:0]             wrdata,
    input  logic [15:0]             rddata
);
    localparam int IW = MASTERS > 1 ? $clog2(MASTERS) : 1;
    localparam int CW = RD_LATENCY > 2 ? $clog2(RD_LATENCY) : 1;
    typedef enum logic [2:0] {IDLE, XFER, WAIT, CAPT, DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] w, win;
    logic [CW-1:0] cnt;
    logic [15:0] addr_q;
    logic we_q;
`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = MASTERS - 1; i >= 0; i--)
            if (m_req[i]) win = IW'(i);
    end
`else
    logic [IW-1:0] ptr;
    logic hit;
    // first requester at or after ptr, wrapping past MASTERS-1
    always_comb begin
        win = '0;
        hit = 1'b0;
        for (int i = 0; i < MASTERS; i++)
            if (!hit && m_req[(int'(ptr) + i) % MASTERS]) begin
                win = IW'((int'(ptr) + i) % MASTERS);
                hit = 1'b1;
            end
    end
    always_ff @(posedge clk)
        if (sclr) ptr <= '0;
        else if (state == IDLE && |m_req) ptr <= (win == IW'(MASTERS - 1)) ? '0 : win + 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (sclr) begin
            state   <= IDLE;
            w       <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wrdata  <= '0;
            be      <= '0;
            m_rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (state == IDLE && |m_req) begin
                w      <= win;
                we_q   <= m_we[win];
                addr_q <= m_addr[16*win +: 16];
                wrdata <= m_wdata[16*win +: 16];
                be     <= m_be[2*win +: 2];
            end
            if (state == CAPT) m_rdata <= rddata;
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = |m_req ? XFER : IDLE;
            XFER:    state_nx = we_q ? DONE : (RD_LATENCY > 1 ? WAIT : CAPT);
            WAIT:    state_nx = (cnt == CW'(RD_LATENCY - 2)) ? CAPT : WAIT;
            CAPT:    state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    assign m_gnt  = (state == XFER || state == WAIT || state == CAPT) ? MASTERS'(1) << w : '0;
    assign m_done = (state == DONE) ? MASTERS'(1) << w : '0;
    assign write  = (state == XFER) && we_q;
    assign rdaddr = addr_q;
    assign wraddr = addr_q;
endmodule

// File: tb/tb_reg_bus_arb.sv
// tb_reg_bus_arb: directed bench for reg_bus_arb with MASTERS=2 (dut a) and MASTERS=3 (dut b).
module tb_reg_bus_arb;
    logic clk = 1'b0;
    logic sclr = 1'b1;
    int total = 0;
    int bad = 0;
`ifdef ARB_FIXED_PRIO_EN
    bit fixed = 1'b1;
`else
    bit fixed = 1'b0;
`endif
    always #5 clk = ~clk;

    logic [1:0]  a_req = '0, a_we = '0, a_gnt, a_done, a_be_o;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [3:0]  a_be = '0;
    logic [15:0] a_rdata, a_rdaddr, a_wraddr, a_wrdata, a_rddata, s1;
    logic        a_write;

    logic [2:0]  b_req = '0, b_we = '0, b_gnt, b_done;
    logic [47:0] b_addr = '0, b_wdata = '0;
    logic [5:0]  b_be = '0;
    logic [15:0] b_rdata, b_rdaddr, b_wraddr, b_wrdata;
    logic [15:0] b_rddata = '0;
    logic [1:0]  b_be_o;
    logic        b_write;

    reg_bus_arb #(.MASTERS(2), .RD_LATENCY(2)) dut_a (
        .clk(clk), .sclr(sclr), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
        .m_wdata(a_wdata), .m_be(a_be), .m_gnt(a_gnt), .m_done(a_done),
        .m_rdata(a_rdata), .rdaddr(a_rdaddr), .wraddr(a_wraddr), .be(a_be_o),
        .write(a_write), .wrdata(a_wrdata), .rddata(a_rddata)
    );
    reg_bus_arb #(.MASTERS(3), .RD_LATENCY(2)) dut_b (
        .clk(clk), .sclr(sclr), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
        .m_wdata(b_wdata), .m_be(b_be), .m_gnt(b_gnt), .m_done(b_done),
        .m_rdata(b_rdata), .rdaddr(b_rdaddr), .wraddr(b_wraddr), .be(b_be_o),
        .write(b_write), .wrdata(b_wrdata), .rddata(b_rddata)
    );

    // two-register slave read path: data stable two edges after rdaddr changes
    always @(posedge clk) begin
        s1 <= (a_rdaddr == 16'h0102) ? 16'h1234 : a_rdaddr ^ 16'h5A5A;
        a_rddata <= s1;
    end

    task step;
        @(posedge clk);
        #1;
    endtask

    task test_reset;
        sclr = 1'b1;
        step;
        step;
        total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%h exp=0", a_gnt); end
        total++; if (a_done !== 2'b00) begin bad++; $display("FAIL rst_done got=%h exp=0", a_done); end
        total++; if (a_write !== 1'b0) begin bad++; $display("FAIL rst_write got=%b exp=0", a_write); end
        total++; if (a_rdaddr !== 16'h0) begin bad++; $display("FAIL rst_rdaddr got=%h exp=0", a_rdaddr); end
        total++; if (a_be_o !== 2'b00) begin bad++; $display("FAIL rst_be got=%b exp=00", a_be_o); end
        total++; if (a_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", a_rdata); end
        total++; if (b_gnt !== 3'b000) begin bad++; $display("FAIL rst_b_gnt got=%b exp=000", b_gnt); end
        sclr = 1'b0;
        step;
    endtask

    task test_write;
        a_we = 2'b01; a_addr[15:0] = 16'h0185; a_wdata[15:0] = 16'hA5A5; a_be[1:0] = 2'b11;
        a_req = 2'b01;
        step;
        total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL wr_gnt got=%b exp=01", a_gnt); end
        total++; if (a_write !== 1'b1) begin bad++; $display("FAIL wr_write got=%b exp=1", a_write); end
        total++; if (a_wraddr !== 16'h0185) begin bad++; $display("FAIL wr_wraddr got=%h exp=0185", a_wraddr); end
        total++; if (a_wrdata !== 16'hA5A5) begin bad++; $display("FAIL wr_wrdata got=%h exp=a5a5", a_wrdata); end
        total++; if (a_be_o !== 2'b11) begin bad++; $display("FAIL wr_be got=%b exp=11", a_be_o); end
        total++; if (a_done !== 2'b00) begin bad++; $display("FAIL wr_done_early got=%b exp=00", a_done); end
        a_addr[15:0] = 16'hFFFF;
        step;
        total++; if (a_write !== 1'b0) begin bad++; $display("FAIL wr_write_len got=%b exp=0", a_write); end
        total++; if (a_done !== 2'b01) begin bad++; $display("FAIL wr_done got=%b exp=01", a_done); end
        total++; if (a_wraddr !== 16'h0185) begin bad++; $display("FAIL wr_hold_addr got=%h exp=0185", a_wraddr); end
        a_req = 2'b00;
        step;
        total++; if (a_done !== 2'b00) begin bad++; $display("FAIL wr_done_pulse got=%b exp=00", a_done); end
    endtask

    task test_read;
        logic saw_w;
        a_we = 2'b00; a_addr[31:16] = 16'h0102; a_req = 2'b10;
        step;
        saw_w = a_write;
        total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL rd_gnt got=%b exp=10", a_gnt); end
        total++; if (a_rdaddr !== 16'h0102) begin bad++; $display("FAIL rd_rdaddr got=%h exp=0102", a_rdaddr); end
        step; saw_w |= a_write;
        step; saw_w |= a_write;
        total++; if (a_done !== 2'b00) begin bad++; $display("FAIL rd_done_early got=%b exp=00", a_done); end
        step; saw_w |= a_write;
        total++; if (a_done !== 2'b10) begin bad++; $display("FAIL rd_done got=%b exp=10", a_done); end
        total++; if (a_rdata !== 16'h1234) begin bad++; $display("FAIL rd_rdata got=%h exp=1234", a_rdata); end
        total++; if (saw_w !== 1'b0) begin bad++; $display("FAIL rd_write got=%b exp=0", saw_w); end
        a_req = 2'b00;
        step;
    endtask

    task test_contention;
        int n, cyc, last;
        logic [1:0] prev, exp_g;
        logic [15:0] exp_d;
        a_we = 2'b00; a_addr = {16'h0020, 16'h0010}; a_req = 2'b11;
        n = 0; cyc = 0; last = 0; prev = 2'b00;
        while (n < 4 && cyc < 60) begin
            step;
            cyc++;
            if (a_gnt !== 2'b00 && prev === 2'b00) begin
                exp_g = (fixed || n % 2 == 0) ? 2'b01 : 2'b10;
                total++; if (a_gnt !== exp_g) begin bad++; $display("FAIL cont_gnt%0d got=%b exp=%b", n, a_gnt, exp_g); end
                if (n > 0) begin
                    total++; if (cyc - last != 5) begin bad++; $display("FAIL cont_gap%0d got=%0d exp=5", n, cyc - last); end
                end
                last = cyc;
                n++;
            end
            if (a_done !== 2'b00) begin
                exp_d = (a_done == 2'b01) ? 16'h5A4A : 16'h5A7A;
                total++; if (a_rdata !== exp_d) begin bad++; $display("FAIL cont_rdata got=%h exp=%h", a_rdata, exp_d); end
            end
            prev = a_gnt;
        end
        total++; if (n != 4) begin bad++; $display("FAIL cont_timeout got=%0d exp=4 grants", n); end
        a_req = 2'b10;
        n = 0; cyc = 0;
        while (n == 0 && cyc < 20) begin
            step;
            cyc++;
            if (a_gnt !== 2'b00 && prev === 2'b00) n = 1;
            prev = a_gnt;
        end
        total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL cont_drop0 got=%b exp=10", a_gnt); end
        a_req = 2'b00;
        repeat (6) step;
    endtask

    task test_reset_mid;
        a_we = 2'b00; a_addr[15:0] = 16'h0030; a_req = 2'b01;
        step;
        step;
        total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL rm_wait_gnt got=%b exp=01", a_gnt); end
        sclr = 1'b1; a_req = 2'b11;
        step;
        total++; if (a_gnt !== 2'b00) begin bad++; $display("FAIL rm_gnt got=%b exp=00", a_gnt); end
        total++; if (a_done !== 2'b00) begin bad++; $display("FAIL rm_done got=%b exp=00", a_done); end
        total++; if (a_write !== 1'b0) begin bad++; $display("FAIL rm_write got=%b exp=0", a_write); end
        total++; if (a_rdaddr !== 16'h0 || a_wraddr !== 16'h0) begin bad++; $display("FAIL rm_addr got=%h/%h exp=0", a_rdaddr, a_wraddr); end
        total++; if (a_wrdata !== 16'h0) begin bad++; $display("FAIL rm_wrdata got=%h exp=0", a_wrdata); end
        total++; if (a_be_o !== 2'b00) begin bad++; $display("FAIL rm_be got=%b exp=00", a_be_o); end
        total++; if (a_rdata !== 16'h0) begin bad++; $display("FAIL rm_rdata got=%h exp=0", a_rdata); end
        sclr = 1'b0;
        step;
        total++; if (a_gnt !== 2'b01) begin bad++; $display("FAIL rm_ptr0 got=%b exp=01", a_gnt); end
        a_req = 2'b10;
        repeat (3) step;
        total++; if (a_done !== 2'b01) begin bad++; $display("FAIL rm_dropped_done got=%b exp=01", a_done); end
        step;
        step;
        total++; if (a_gnt !== 2'b10) begin bad++; $display("FAIL rm_m1_gnt got=%b exp=10", a_gnt); end
        a_req = 2'b00;
        repeat (6) step;
    endtask

    task test_wrap;
        logic [2:0] exp_g;
        b_we = 3'b111; b_be = 6'b111111;
        b_addr = {16'h0302, 16'h0301, 16'h0300};
        b_wdata = {16'hC002, 16'hC001, 16'hC000};
        b_req = 3'b100;
        step;
        total++; if (b_gnt !== 3'b100) begin bad++; $display("FAIL wrap_gnt2 got=%b exp=100", b_gnt); end
        total++; if (b_wraddr !== 16'h0302) begin bad++; $display("FAIL wrap_addr2 got=%h exp=0302", b_wraddr); end
        step;
        total++; if (b_done !== 3'b100) begin bad++; $display("FAIL wrap_done2 got=%b exp=100", b_done); end
        b_req = 3'b101;
        step;
        step;
        total++; if (b_gnt !== 3'b001) begin bad++; $display("FAIL wrap_gnt0 got=%b exp=001", b_gnt); end
        total++; if (b_wrdata !== 16'hC000) begin bad++; $display("FAIL wrap_wdata0 got=%h exp=c000", b_wrdata); end
        step;
        step;
        step;
        exp_g = fixed ? 3'b001 : 3'b100;
        total++; if (b_gnt !== exp_g) begin bad++; $display("FAIL wrap_next got=%b exp=%b", b_gnt, exp_g); end
        b_req = 3'b000;
        repeat (4) step;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_contention;
        test_reset_mid;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
